// File: rtl/store_commit_buffer.sv
// store_commit_buffer
//   Drain queue for retired stores. Stores arrive in program order from the
//   ROB retire port. They are held in a circular FIFO and written to data
//   memory one at a time over a wr_en/ack handshake. A combinational
//   word-granular address match tells a pending load whether it hits any
//   store that has not yet been written.
//
// Ports
//   i_clk, i_rst_n            core clock, async active-low reset
//   i_retire_valid/addr/data  retiring store from the ROB
//   o_retire_ready            room for a store (registered count != DEPTH)
//   o_mem_wr_en/addr/wdata    registered write request to data memory
//   i_mem_wr_ack              memory accepted the current write
//   i_ld_check_valid/addr     load address to check against buffered stores
//   o_ld_conflict             load word matches a buffered store
//   o_count, o_empty          occupancy
//
// Drain FSM
//   state | meaning
//   IDLE  | no write outstanding; launch the head entry if the queue is non-empty
//   WRITE | head entry on the memory port; wait for ack, then pop

module store_commit_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_retire_valid,
  input  logic [ADDR_W-1:0]          i_retire_addr,
  input  logic [DATA_W-1:0]          i_retire_data,
  output logic                       o_retire_ready,
  output logic                       o_mem_wr_en,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic [DATA_W-1:0]          o_mem_wdata,
  input  logic                       i_mem_wr_ack,
  input  logic                       i_ld_check_valid,
  input  logic [ADDR_W-1:0]          i_ld_check_addr,
  output logic                       o_ld_conflict,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ent_addr_q [DEPTH];
  logic [DATA_W-1:0]   ent_data_q [DEPTH];
  logic [DEPTH-1:0]    ent_valid_q;
  logic [PW-1:0]       head_q, tail_q;
  logic [CW-1:0]       count_q, count_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                push, pop;
  logic                hit;

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot for a same-cycle push.
  assign o_retire_ready = (count_q != FULL);
  assign push           = i_retire_valid && o_retire_ready;

  always_comb begin
    state_d     = state_q;
    mem_wr_en_d = mem_wr_en_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          mem_addr_d  = ent_addr_q[head_q];
          mem_wdata_d = ent_data_q[head_q];
          mem_wr_en_d = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (i_mem_wr_ack) begin
          pop         = 1'b1;
          mem_wr_en_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ent_valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      // head and tail can only coincide here when empty (no pop) or full
      // (no push), so the invalidate and the fill never collide.
      if (pop) begin
        ent_valid_q[head_q] <= 1'b0;
        head_q              <= head_q + PW'(1);
      end
      if (push) begin
        ent_addr_q[tail_q]  <= i_retire_addr;
        ent_data_q[tail_q]  <= i_retire_data;
        ent_valid_q[tail_q] <= 1'b1;
        tail_q              <= tail_q + PW'(1);
      end
    end
  end

  // Word-granular match against registered entries; the in-flight head is
  // still valid, a same-cycle push is not yet visible.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid_q[i] && (ent_addr_q[i][ADDR_W-1:2] == i_ld_check_addr[ADDR_W-1:2]))
        hit = 1'b1;
    end
  end

  assign o_ld_conflict = i_ld_check_valid && hit;
  assign o_mem_wr_en   = mem_wr_en_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_count       = count_q;
  assign o_empty       = (count_q == '0);

endmodule

// File: doc/store_commit_buffer.md
# store_commit_buffer

Retired-store drain queue for the out-of-order core. It accepts stores from the reorder buffer's retire port in program order and holds them in a circular FIFO. It writes them one at a time to data memory over a request/acknowledge handshake. It also reports whether a pending load address matches any store that has not yet been written.

## Interface
- DEPTH, 4, number of buffered stores; power of two, 2 or more
- ADDR_W, 32, address width
- DATA_W, 32, store data width
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_retire_valid  in  1  ROB presents a retiring store this cycle
- i_retire_addr  in  ADDR_W  store byte address
- i_retire_data  in  DATA_W  store data
- o_retire_ready  out  1  buffer can accept a store this cycle
- o_mem_wr_en  out  1  write request to data memory
- o_mem_addr  out  ADDR_W  write address; registered
- o_mem_wdata  out  DATA_W  write data; registered
- i_mem_wr_ack  in  1  memory accepted the current write
- i_ld_check_valid  in  1  a load address is being checked
- i_ld_check_addr  in  ADDR_W  load byte address
- o_ld_conflict  out  1  load word matches a buffered store
- o_count  out  $clog2(DEPTH)+1  occupied entries
- o_empty  out  1  o_count == 0

## Operation
- Storage: DEPTH entries of {addr, data, valid} with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Occupancy is held in a separate counter, so full and empty are never ambiguous.
- Push: occurs at a rising edge when i_retire_valid && o_retire_ready. The entry is written at tail, tail advances and count increments.
- o_retire_ready = (count != DEPTH), derived from the registered count. A pop in the same cycle does not make room. When full, ready stays low even if an ack arrives that cycle.
- i_retire_valid while ready is low: the store is ignored. The ROB must hold the store until ready is high.
- Drain FSM, two states:
  - IDLE: if count > 0, register head addr/data onto o_mem_addr/o_mem_wdata, set o_mem_wr_en, go to WRITE. Otherwise stay in IDLE.
  - WRITE: hold o_mem_wr_en, o_mem_addr and o_mem_wdata stable until i_mem_wr_ack is sampled high. At that edge: clear wr_en, invalidate the head entry, advance head, decrement count, go to IDLE.
- i_mem_wr_ack while in IDLE is ignored.
- The store being written stays in the FIFO, and stays counted, until it is acked.
- Simultaneous push and ack, count neither 0 nor DEPTH: count is unchanged, tail advances and head advances.
- Load conflict is combinational:
  - o_ld_conflict = i_ld_check_valid && any valid entry with entry.addr[ADDR_W-1:2] == i_ld_check_addr[ADDR_W-1:2].
  - The in-flight head entry is included.
  - A store pushed in the same cycle is not included; it becomes visible the next cycle.
- No flush input: stores that have retired are architecturally committed and must always drain.

## Timing
- Reset, asynchronous and effective immediately:
  - count = 0, head = tail = 0, all valid bits = 0, state = IDLE
  - o_mem_wr_en = 0, o_mem_addr = 0, o_mem_wdata = 0
  - o_retire_ready = 1, o_empty = 1, o_count = 0, o_ld_conflict = 0
- Reset during WRITE drops the pending store and deasserts wr_en at once.
- Latency from accepting a store into an empty buffer at edge N:
  - o_empty falls after edge N.
  - o_mem_wr_en rises after edge N+1.
  - If ack is high in that cycle, wr_en falls after edge N+2 and count returns to 0.
- Peak drain rate is one store per 2 cycles, because of the IDLE cycle between writes.
- o_mem_addr and o_mem_wdata change only on the IDLE→WRITE transition.

## Test plan
- Reset, then one push of addr 0x100, data 0xDEADBEEF:
  - wr_en goes high 2 cycles later with 0x100/0xDEADBEEF.
  - Ack on the first cycle of wr_en → o_empty = 1 one cycle later.
- Push 4 stores back to with ack held low:
  - o_count = 4 and o_retire_ready = 0.
  - A fifth valid store is dropped and count stays 4.
  - After ack, ready returns the next cycle.
- Hold ack low for 5 cycles during WRITE: wr_en, addr and data remain stable all 5 cycles. Then ack → exactly one pop.
- Push 6 stores while acking continuously:
  - Stores drain in order, the pointers wrap past DEPTH, and memory sees all 6 address/data pairs in order.
  - Occupancy never exceeds 4.
- Load conflict:
  - Buffered store at 0x204; check 0x206 → conflict = 1.
  - Check 0x208 → conflict = 0.
  - Check 0x206 with i_ld_check_valid = 0 → conflict = 0.
  - Conflict stays 1 until the ack of 0x204.
- Assert reset mid-WRITE with 3 entries:
  - wr_en = 0, count = 0 and ready = 1 immediately.
  - After release, no write is issued.
